// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    // States that hold mem_req high and wait on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Opcode/funct decode into ALU op, immediate extension mode and legality.
module mc_alu_dec
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 5
) (
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    output logic [ALUCTL_W-1:0] alu_ctrl_o,
    output logic                ext_zero_o,
    output logic                illegal_o
);

    // Pure lookup; unknown opcodes and unknown R-type functs flag illegal.
    always_comb begin
        alu_ctrl_o = ALUCTL_W'(ALU_ADD);
        ext_zero_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALUCTL_W'(ALU_ADD);
                    FN_SUB:  alu_ctrl_o = ALUCTL_W'(ALU_SUB);
                    FN_AND:  alu_ctrl_o = ALUCTL_W'(ALU_AND);
                    FN_OR:   alu_ctrl_o = ALUCTL_W'(ALU_OR);
                    FN_SLT:  alu_ctrl_o = ALUCTL_W'(ALU_SLT);
                    default: illegal_o  = 1'b1;
                endcase
            end
            OP_ADDI: alu_ctrl_o = ALUCTL_W'(ALU_ADD);
            OP_SLTI: alu_ctrl_o = ALUCTL_W'(ALU_SLT);
            OP_ANDI: begin
                alu_ctrl_o = ALUCTL_W'(ALU_AND);
                ext_zero_o = 1'b1;
            end
            OP_ORI: begin
                alu_ctrl_o = ALUCTL_W'(ALU_OR);
                ext_zero_o = 1'b1;
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: alu_ctrl_o = ALUCTL_W'(ALU_ADD);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory handshake, wait timeout and trap.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTL_W    = 5,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                ior_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_zero,
    output logic [ALUCTL_W-1:0] alu_ctrl,
    output logic                alu_reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]          cause_q, cause_d;
    logic                timeout_hit;
    logic [5:0]          opcode;
    logic [ALUCTL_W-1:0] dec_alu_ctrl;
    logic                dec_ext_zero;
    logic                dec_illegal;
    logic                unused_instr;

    assign opcode       = instr[31:26];
    assign unused_instr = ^instr[25:6];

    mc_alu_dec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_dec (
        .opcode_i   (opcode),
        .funct_i    (instr[5:0]),
        .alu_ctrl_o (dec_alu_ctrl),
        .ext_zero_o (dec_ext_zero),
        .illegal_o  (dec_illegal)
    );

    // Saturating wait count; timeout fires on the cycle that would reach TIMEOUT_CYC.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYC);

    // State, wait counter and trap cause registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and output decode; everything is forced low while in reset.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ior_d      = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        ext_zero   = 1'b0;
        alu_ctrl   = ALUCTL_W'(ALU_ADD);
        alu_reg_we = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b  = 2'd3;
                    alu_reg_we = 1'b1;
                    case (opcode)
                        OP_LW, OP_SW:                      state_d = MEMADR;
                        OP_RTYPE:                          state_d = EXEC;
                        OP_BEQ, OP_BNE:                    state_d = BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
                        OP_J:                              state_d = JUMP;
                        default: begin
                            state_d = TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    alu_reg_we = 1'b1;
                    state_d    = (opcode == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD, MEMWR: begin
                    mem_req   = 1'b1;
                    ior_d     = 1'b1;
                    mem_write = (state_q == MEMWR);
                    if (mem_ready) begin
                        state_d = (state_q == MEMRD) ? MEMWB : FETCH;
                    end
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = FETCH;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = dec_alu_ctrl;
                    if (dec_illegal) begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        alu_reg_we = 1'b1;
                        state_d    = RWB;
                    end
                end
                RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = FETCH;
                end
                IEXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    alu_ctrl   = dec_alu_ctrl;
                    ext_zero   = dec_ext_zero;
                    alu_reg_we = 1'b1;
                    state_d    = IWB;
                end
                IWB: begin
                    reg_write = 1'b1;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALUCTL_W'(ALU_SUB);
                    branch    = 1'b1;
                    branch_ne = (opcode == OP_BNE);
                    pc_src    = 2'd1;
                    state_d   = FETCH;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    state_d  = FETCH;
                end
                TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: state_d = FETCH;
            endcase
            // Stalled memory access: count, and trap on timeout unless mem_ready arrived.
            if (is_mem_state(state_q) && !mem_ready) begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm (TIMEOUT_CYC = 4).
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ior_d;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [4:0] alu_ctrl;
        logic       alu_reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
        logic [1:0] trap_cause;
    } obs_t;

    localparam logic [4:0] A_ADD = 5'd0;
    localparam logic [4:0] A_SUB = 5'd1;
    localparam logic [4:0] A_OR  = 5'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_req, mem_write, ior_d, ir_write, pc_write, branch, branch_ne;
    logic [1:0]  pc_src, alu_src_b, trap_cause;
    logic        alu_src_a, ext_zero, alu_reg_we, reg_dst, mem_to_reg, reg_write, trap;
    logic [4:0]  alu_ctrl;
    obs_t        obs;

    int checks = 0;
    int errors = 0;

    obs_t  exp_q[$];
    obs_t  mask_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    mc_ctrl_fsm #(
        .ALUCTL_W    (5),
        .TIMEOUT_CYC (4),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ior_d      (ior_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_ctrl   (alu_ctrl),
        .alu_reg_we (alu_reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign obs = {mem_req, mem_write, ior_d, ir_write, pc_write, branch, branch_ne, pc_src,
                  alu_src_a, alu_src_b, ext_zero, alu_ctrl, alu_reg_we, reg_dst, mem_to_reg,
                  reg_write, trap, trap_cause};

    // Expected per-state output vectors.
    function automatic obs_t e_fetch(input logic rdy);
        obs_t e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_ctrl = A_ADD;
        e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction
    function automatic obs_t e_decode();
        obs_t e = '0;
        e.alu_src_b = 2'd3; e.alu_ctrl = A_ADD; e.alu_reg_we = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_memadr();
        obs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_ctrl = A_ADD; e.alu_reg_we = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_mem(input logic wr);
        obs_t e = '0;
        e.mem_req = 1'b1; e.ior_d = 1'b1; e.mem_write = wr;
        return e;
    endfunction
    function automatic obs_t e_memwb();
        obs_t e = '0;
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_exec(input logic [4:0] ctl);
        obs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_ctrl = ctl; e.alu_reg_we = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_rwb();
        obs_t e = '0;
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_iexec(input logic [4:0] ctl, input logic ez);
        obs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_ctrl = ctl; e.ext_zero = ez;
        return e;
    endfunction
    function automatic obs_t e_iwb();
        obs_t e = '0;
        e.reg_write = 1'b1;
        return e;
    endfunction
    function automatic obs_t e_branch(input logic ne);
        obs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_ctrl = A_SUB; e.branch = 1'b1; e.branch_ne = ne; e.pc_src = 2'd1;
        return e;
    endfunction
    function automatic obs_t e_jump();
        obs_t e = '0;
        e.pc_write = 1'b1; e.pc_src = 2'd2;
        return e;
    endfunction
    function automatic obs_t e_trap(input logic [1:0] cause);
        obs_t e = '0;
        e.trap = 1'b1; e.trap_cause = cause;
        return e;
    endfunction

    // One clock cycle: drive inputs, queue the expectation, then compare the settled outputs.
    task automatic step(input logic rst, input logic rdy, input obs_t e, input obs_t m, input string tag);
        obs_t exp_v, mask_v;
        string t;
        rst_n     = rst;
        mem_ready = rdy;
        exp_q.push_back(e);
        mask_q.push_back(m);
        tag_q.push_back(tag);
        #2;
        exp_v  = exp_q.pop_front();
        mask_v = mask_q.pop_front();
        t      = tag_q.pop_front();
        checks++;
        assert ((obs & mask_v) === (exp_v & mask_v))
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs & mask_v, exp_v & mask_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t all_m, iexec_m, ill_m;
        all_m = '1;
        iexec_m = '1;
        iexec_m.alu_reg_we = 1'b0;
        ill_m = '0;
        ill_m.reg_write = 1'b1; ill_m.alu_reg_we = 1'b1; ill_m.trap = 1'b1;
        ill_m.trap_cause = 2'b11; ill_m.mem_req = 1'b1; ill_m.ir_write = 1'b1; ill_m.pc_write = 1'b1;

        rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, '0, all_m, "reset_zero");

        // add with mem_ready held high throughout (ignored outside memory states)
        instr = 32'h0109_5020;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "add_fetch");
        step(1'b1, 1'b1, e_decode(),    all_m, "add_decode");
        step(1'b1, 1'b1, e_exec(A_ADD), all_m, "add_exec");
        step(1'b1, 1'b1, e_rwb(),       all_m, "add_rwb");

        // lw with 3-cycle delay in FETCH and MEMRD
        instr = 32'h8D09_0004;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e_fetch(1'b0), all_m, "lw_fetch_wait");
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "lw_fetch_done");
        step(1'b1, 1'b0, e_decode(),    all_m, "lw_decode");
        step(1'b1, 1'b0, e_memadr(),    all_m, "lw_memadr");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e_mem(1'b0), all_m, "lw_memrd_wait");
        step(1'b1, 1'b1, e_mem(1'b0),   all_m, "lw_memrd_done");
        step(1'b1, 1'b0, e_memwb(),     all_m, "lw_memwb");

        // bne, ori, j
        instr = 32'h1509_0003;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "bne_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "bne_decode");
        step(1'b1, 1'b0, e_branch(1'b1), all_m, "bne_branch");
        instr = 32'h3509_0FF0;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "ori_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "ori_decode");
        step(1'b1, 1'b0, e_iexec(A_OR, 1'b1), iexec_m, "ori_iexec");
        step(1'b1, 1'b0, e_iwb(),       all_m, "ori_iwb");
        instr = 32'h0800_0010;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "j_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "j_decode");
        step(1'b1, 1'b0, e_jump(),      all_m, "j_jump");

        // lw interrupted by a one-cycle reset during the MEMRD wait
        instr = 32'h8D09_0004;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "rst_lw_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "rst_lw_decode");
        step(1'b1, 1'b0, e_memadr(),    all_m, "rst_lw_memadr");
        step(1'b1, 1'b0, e_mem(1'b0),   all_m, "rst_lw_memrd_wait");
        step(1'b1, 1'b0, e_mem(1'b0),   all_m, "rst_lw_memrd_wait");
        step(1'b0, 1'b0, '0,            all_m, "rst_mid_zero");

        // sw that times out in MEMWR after 4 wait cycles
        instr = 32'hAD09_0008;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e_fetch(1'b0), all_m, "sw_fetch_after_rst");
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "sw_fetch_done");
        step(1'b1, 1'b0, e_decode(),    all_m, "sw_decode");
        step(1'b1, 1'b0, e_memadr(),    all_m, "sw_memadr");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, e_mem(1'b1), all_m, "sw_memwr_wait");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e_trap(2'd2), all_m, "sw_trap_bus");
        step(1'b1, 1'b1, e_trap(2'd2),  all_m, "sw_trap_sticky");

        // illegal opcode 0x3F
        step(1'b0, 1'b0, '0,            all_m, "rst_from_trap");
        instr = 32'hFC00_0000;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "ill_op_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "ill_op_decode");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, e_trap(2'd1), all_m, "ill_op_trap");

        // R-type with illegal funct 0x07
        step(1'b0, 1'b0, '0,            all_m, "rst_from_trap2");
        instr = 32'h0109_5007;
        step(1'b1, 1'b1, e_fetch(1'b1), all_m, "ill_fn_fetch");
        step(1'b1, 1'b0, e_decode(),    all_m, "ill_fn_decode");
        step(1'b1, 1'b0, '0,            ill_m, "ill_fn_exec");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, e_trap(2'd1), all_m, "ill_fn_trap");

        // trap cleared by reset
        step(1'b0, 1'b0, '0,            all_m, "rst_final");
        step(1'b1, 1'b0, e_fetch(1'b0), all_m, "fetch_after_trap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
